// File: rtl/ptw_pkg.sv
// Shared types and default widths for the page-table-walk memory arbiter.
// Two walkers (instruction side, data side) share one memory port.
package ptw_pkg;

  localparam int unsigned PTW_ADDR_W         = 64;
  localparam int unsigned PTW_DATA_W         = 64;
  localparam int unsigned PTW_TIMEOUT_CYCLES = 255;

  // Arbiter FSM states, 2-bit encoding; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Which walker owns the memory port.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage : ptw_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. On simultaneous requests the side that was
// not granted last wins; the pointer moves only when a grant is taken.
// After reset the pointer names the instruction side, so data wins first.
module rr_arbiter2
  import ptw_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  input  logic   i_valid_i,
  input  logic   i_valid_d,
  output logic   o_grant,
  output owner_e o_winner
);

  owner_e r_last;

  // Pick a winner from the current requests and the last-granted pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    o_winner = OWN_I;
    o_grant  = i_en & (i_valid_i | i_valid_d);
    if (i_valid_i && i_valid_d) begin
      o_winner = (r_last == OWN_I) ? OWN_D : OWN_I;
    end else if (i_valid_d) begin
      o_winner = OWN_D;
    end
  end

  // Remember who was granted last; only a taken grant moves the pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      r_last <= OWN_I;
    end else if (o_grant) begin
      r_last <= o_winner;
    end
  end

endmodule : rr_arbiter2

// File: rtl/ptw_mem_arbiter.sv
// Shares a single memory port between the instruction-side and data-side
// Sv39 page-table walkers, one transaction outstanding at a time.
// A walker that sets its lock bit keeps the port across consecutive levels
// of a walk until it drops valid.
// Optional: define PTW_ARB_TIMEOUT_EN to add a WAIT-state watchdog that
// returns an error response after TIMEOUT_CYCLES cycles without data.
module ptw_mem_arbiter
  import ptw_pkg::*;
#(
  parameter int unsigned ADDR_W         = PTW_ADDR_W,
  parameter int unsigned DATA_W         = PTW_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = PTW_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-side walker
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_lock,
  output logic              i_req_ready,
  // data-side walker
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_lock,
  output logic              d_req_ready,
  // response to the owning walker
  output logic              i_resp_valid,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  // shared memory port
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ptw_mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            r_owner;
  logic              r_lock;
  logic [ADDR_W-1:0] r_addr;
  logic              r_i_resp_valid;
  logic              r_d_resp_valid;
  logic [DATA_W-1:0] r_resp_data;

  logic              w_owner_valid;
  logic              w_regrant;
  logic              w_arb_en;
  logic              w_arb_grant;
  owner_e            w_arb_winner;
  logic              w_accept;
  owner_e            w_sel_owner;
  logic              w_sel_lock;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_resp_take;
  logic              w_timeout;

  // A locked owner that is still requesting skips arbitration entirely;
  // if it has dropped valid, ordinary round-robin applies and the pointer
  // already names it, so the other side wins a tie.
  assign w_owner_valid = (r_owner == OWN_I) ? i_req_valid : d_req_valid;
  assign w_regrant     = (r_state == ST_IDLE) & r_lock & w_owner_valid;
  assign w_arb_en      = (r_state == ST_IDLE) & ~w_regrant;
  assign w_accept      = w_regrant | w_arb_grant;
  assign w_sel_owner   = w_regrant ? r_owner : w_arb_winner;
  assign w_sel_lock    = (w_sel_owner == OWN_D) ? d_req_lock : i_req_lock;
  assign w_sel_addr    = (w_sel_owner == OWN_D) ? d_req_addr : i_req_addr;
  assign w_resp_take   = (r_state == ST_WAIT) & mem_resp_valid;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_arb_en),
    .i_valid_i (i_req_valid),
    .i_valid_d (d_req_valid),
    .o_grant   (w_arb_grant),
    .o_winner  (w_arb_winner)
  );

`ifdef PTW_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_resp_err;

  // Count cycles spent in WAIT; restarts from zero on every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Fires on the last allowed WAIT cycle when memory has still not answered.
  assign w_timeout = (r_state == ST_WAIT) & ~mem_resp_valid &
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // The error flag accompanies the timeout response pulse only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_resp_err <= 1'b0;
    end else begin
      r_resp_err <= w_timeout;
    end
  end

  assign resp_err = r_resp_err;
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; memory responses outside WAIT are ignored.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept)                 w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (mem_req_ready)            w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_resp_take || w_timeout) w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: request-ready pulse on acceptance, memory request in ISSUE.
  always_comb begin
    i_req_ready   = 1'b0;
    d_req_ready   = 1'b0;
    mem_req_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        i_req_ready = w_accept & (w_sel_owner == OWN_I);
        d_req_ready = w_accept & (w_sel_owner == OWN_D);
      end
      ST_ISSUE: mem_req_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the accepted request and register the response back to its owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner        <= OWN_I;
      r_lock         <= 1'b0;
      r_addr         <= '0;
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
      r_resp_data    <= '0;
    end else begin
      r_i_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;

      if (w_accept) begin
        r_owner <= w_sel_owner;
        r_lock  <= w_sel_lock;
        r_addr  <= w_sel_addr;
      end else if ((r_state == ST_IDLE) && r_lock && !w_owner_valid) begin
        r_lock <= 1'b0;
      end

      if (w_resp_take) begin
        r_i_resp_valid <= (r_owner == OWN_I);
        r_d_resp_valid <= (r_owner == OWN_D);
        r_resp_data    <= mem_resp_data;
      end else if (w_timeout) begin
        r_i_resp_valid <= (r_owner == OWN_I);
        r_d_resp_valid <= (r_owner == OWN_D);
        r_resp_data    <= '0;
        r_lock         <= 1'b0;
      end
    end
  end

  assign i_resp_valid = r_i_resp_valid;
  assign d_resp_valid = r_d_resp_valid;
  assign resp_data    = r_resp_data;
  assign mem_req_addr = r_addr;

endmodule : ptw_mem_arbiter

// File: tb/tb_ptw_mem_arbiter.sv
// Directed testbench for ptw_mem_arbiter. Define PTW_ARB_TIMEOUT_EN to also
// exercise the WAIT-state watchdog (TIMEOUT_CYCLES = 10).
module tb_ptw_mem_arbiter;

`ifdef PTW_ARB_TIMEOUT_EN
  localparam int unsigned TB_TMO = 10;
`else
  localparam int unsigned TB_TMO = 255;
`endif

  logic        clk;
  logic        rst;
  logic        i_req_valid, d_req_valid;
  logic [63:0] i_req_addr, d_req_addr;
  logic        i_req_lock, d_req_lock;
  logic        i_req_ready, d_req_ready;
  logic        i_resp_valid, d_resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  int n_cmp = 0;
  int n_err = 0;

  // grant log: 1 = data side, 0 = instruction side, with cycle index
  logic g_who[$];
  int   g_when[$];

  ptw_mem_arbiter #(
    .ADDR_W         (64),
    .DATA_W         (64),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .i_req_addr     (i_req_addr),
    .i_req_lock     (i_req_lock),
    .i_req_ready    (i_req_ready),
    .d_req_valid    (d_req_valid),
    .d_req_addr     (d_req_addr),
    .d_req_lock     (d_req_lock),
    .d_req_ready    (d_req_ready),
    .i_resp_valid   (i_resp_valid),
    .d_resp_valid   (d_resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    i_req_valid    = 1'b0;
    d_req_valid    = 1'b0;
    i_req_lock     = 1'b0;
    d_req_lock     = 1'b0;
    i_req_addr     = '0;
    d_req_addr     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Log up to four grants; optionally drop d_req_valid after the third
  // data grant and i_req_valid after any instruction grant.
  task automatic collect(input bit drop_mode);
    bit drop_d = 1'b0;
    bit drop_i = 1'b0;
    int cnt_d  = 0;
    g_who.delete();
    g_when.delete();
    for (int c = 0; c < 40 && g_who.size() < 4; c++) begin
      if (drop_d) d_req_valid = 1'b0;
      if (drop_i) i_req_valid = 1'b0;
      #1;
      check("ready_exclusive", {63'd0, i_req_ready & d_req_ready}, 64'd0);
      if (d_req_ready) begin
        g_who.push_back(1'b1);
        g_when.push_back(c);
        cnt_d++;
        if (drop_mode && cnt_d == 3) drop_d = 1'b1;
      end else if (i_req_ready) begin
        g_who.push_back(1'b0);
        g_when.push_back(c);
        if (drop_mode) drop_i = 1'b1;
      end
      cyc();
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    check("rst_i_ready",   i_req_ready,   0);
    check("rst_d_ready",   d_req_ready,   0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_addr",  mem_req_addr,  0);
    check("rst_i_resp",    i_resp_valid,  0);
    check("rst_d_resp",    d_resp_valid,  0);
    check("rst_data",      resp_data,     0);
    check("rst_err",       resp_err,      0);

    // ---------------- single I request, best-case latency ----------------
    i_req_valid   = 1'b1;
    i_req_addr    = 64'h0000_0000_8000_1008;
    mem_req_ready = 1'b1;
    #1;
    check("t1_i_ready", i_req_ready, 1);
    check("t1_d_ready", d_req_ready, 0);
    cyc();
    i_req_valid = 1'b0;
    #1;
    check("t1_mem_valid", mem_req_valid, 1);
    check("t1_mem_addr",  mem_req_addr,  64'h0000_0000_8000_1008);
    cyc();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h0000_0000_2000_0C01;
    #1;
    check("t1_resp_early", i_resp_valid, 0);
    cyc();
    mem_resp_valid = 1'b0;
    #1;
    check("t1_i_resp",  i_resp_valid, 1);
    check("t1_d_resp",  d_resp_valid, 0);
    check("t1_data",    resp_data,    64'h0000_0000_2000_0C01);
    check("t1_err",     resp_err,     0);
    cyc();
    check("t1_resp_pulse", i_resp_valid, 0);
    check("t1_data_hold",  resp_data,    64'h0000_0000_2000_0C01);

    // ---------------- round-robin on simultaneous requests ----------------
    do_reset();
    i_req_valid    = 1'b1;
    d_req_valid    = 1'b1;
    i_req_addr     = 64'h0000_0000_8000_2000;
    d_req_addr     = 64'h0000_0000_8000_3000;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h0000_0000_1111_0001;
    collect(1'b0);
    check("t2_grant_count", g_who.size(), 4);
    check("t2_grant0", g_who[0], 1);
    check("t2_grant1", g_who[1], 0);
    check("t2_grant2", g_who[2], 1);
    check("t2_grant3", g_who[3], 0);
    check("t2_when3",  g_when[3], 9);

    // ---------------- locked D walk with I waiting ----------------
    do_reset();
    d_req_valid    = 1'b1;
    d_req_lock     = 1'b1;
    d_req_addr     = 64'h0000_0000_8000_4000;
    i_req_valid    = 1'b1;
    i_req_addr     = 64'h0000_0000_8000_5000;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h0000_0000_2222_0001;
    collect(1'b1);
    check("t3_grant_count", g_who.size(), 4);
    check("t3_grant0", g_who[0], 1);
    check("t3_grant1", g_who[1], 1);
    check("t3_grant2", g_who[2], 1);
    check("t3_grant3", g_who[3], 0);
    check("t3_when1",  g_when[1], 3);
    check("t3_when2",  g_when[2], 6);
    check("t3_when3",  g_when[3], 9);

    // ---------------- ISSUE stall with memory not ready ----------------
    do_reset();
    d_req_valid = 1'b1;
    d_req_addr  = 64'h0000_0000_8000_6018;
    #1;
    check("t4_d_ready", d_req_ready, 1);
    cyc();
    d_req_valid = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 64'h0000_0000_8000_7000;
    for (int k = 0; k < 5; k++) begin
      mem_resp_valid = (k == 2);
      #1;
      check("t4_stall_valid",  mem_req_valid, 1);
      check("t4_stall_addr",   mem_req_addr,  64'h0000_0000_8000_6018);
      check("t4_stall_iready", i_req_ready,   0);
      check("t4_stall_dresp",  d_resp_valid,  0);
      cyc();
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    #1;
    check("t4_hs_valid", mem_req_valid, 1);
    cyc();
    mem_req_ready = 1'b0;
    #1;
    check("t4_wait_no_req", mem_req_valid, 0);
    check("t4_wait_iready", i_req_ready,   0);
    cyc();
    check("t4_wait_dresp", d_resp_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h0000_0000_3333_0C01;
    cyc();
    mem_resp_valid = 1'b0;
    #1;
    check("t4_d_resp",    d_resp_valid, 1);
    check("t4_i_resp",    i_resp_valid, 0);
    check("t4_data",      resp_data,    64'h0000_0000_3333_0C01);
    check("t4_i_granted", i_req_ready,  1);
    i_req_valid = 1'b0;
    cyc();
    check("t4_no_extra",   d_resp_valid,  0);
    check("t4_idle_noreq", mem_req_valid, 0);

`ifdef PTW_ARB_TIMEOUT_EN
    // ---------------- WAIT watchdog ----------------
    d_req_valid   = 1'b1;
    d_req_addr    = 64'h0000_0000_8000_8000;
    mem_req_ready = 1'b1;
    #1;
    check("t6_d_ready", d_req_ready, 1);
    cyc();
    d_req_valid = 1'b0;
    cyc();
    mem_req_ready = 1'b0;
    for (int w = 1; w <= 10; w++) begin
      #1;
      check("t6_wait_quiet", d_resp_valid, 0);
      cyc();
    end
    check("t6_d_resp", d_resp_valid, 1);
    check("t6_i_resp", i_resp_valid, 0);
    check("t6_err",    resp_err,     1);
    check("t6_data",   resp_data,    0);
    cyc();
    check("t6_err_pulse", resp_err,     0);
    check("t6_resp_done", d_resp_valid, 0);
`endif

    // ---------------- reset during WAIT ----------------
    do_reset();
    i_req_valid   = 1'b1;
    i_req_addr    = 64'h0000_0000_8000_9000;
    mem_req_ready = 1'b1;
    #1;
    check("t5_i_ready", i_req_ready, 1);
    cyc();
    i_req_valid = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 64'h0000_0000_4444_0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_no_i_resp", i_resp_valid,  0);
      check("t5_no_d_resp", d_resp_valid,  0);
      check("t5_no_mem",    mem_req_valid, 0);
      cyc();
    end
    mem_resp_valid = 1'b0;
    d_req_valid    = 1'b1;
    d_req_addr     = 64'h0000_0000_8000_A000;
    #1;
    check("t5_idle_d_ready", d_req_ready, 1);
    check("t5_data_cleared", resp_data,   0);
    d_req_valid = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ptw_mem_arbiter

// File: doc/ptw_mem_arbiter.md
PTW_MEM_ARBITER -- requirements
Module: ptw_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, width of request address.
REQ-002 Parameter DATA_W, default 64, width of PTE/response data.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, wait-state watchdog limit; used only under REQ-030.
REQ-004 Port clk  in  1  sole clock; all logic on rising edge.
REQ-005 Port rst  in  1  reset, synchronous, active-low.
REQ-006 Ports i_req_valid  in  1, i_req_addr  in  ADDR_W, i_req_lock  in  1, i_req_ready  out  1: instruction-side page-walk request channel.
REQ-007 Ports d_req_valid  in  1, d_req_addr  in  ADDR_W, d_req_lock  in  1, d_req_ready  out  1: data-side page-walk request channel.
REQ-008 Ports i_resp_valid  out  1, d_resp_valid  out  1, resp_data  out  DATA_W, resp_err  out  1: response to the owning requester.
REQ-009 Ports mem_req_valid  out  1, mem_req_addr  out  ADDR_W, mem_req_ready  in  1, mem_resp_valid  in  1, mem_resp_data  in  DATA_W: single shared memory port.

Function
REQ-010 The block shall share one memory port between two Sv39 walkers with at most one transaction outstanding.
REQ-011 States: IDLE, ISSUE, WAIT; the encoding shall be 2 bits.
REQ-012 IDLE: on any request valid, the block shall select a winner, capture its address and owner, assert its req_ready for exactly that cycle, and go to ISSUE next cycle.
REQ-013 Arbitration shall be round-robin: on simultaneous valid, the side not granted last wins; after reset the data side wins first.
REQ-014 ISSUE: mem_req_valid shall be 1 with the captured address, held stable until mem_req_ready; on handshake the block goes to WAIT.
REQ-015 WAIT: on mem_resp_valid the block shall register mem_resp_data into resp_data and pulse the owner's resp_valid for one cycle, one cycle after mem_resp_valid (latency 1).
REQ-016 After the response, if the owner's lock was 1 when its request was accepted and the owner's valid is 1, the owner shall be regranted without arbitration (multi-level walk stays atomic); otherwise the block shall return to IDLE.
REQ-017 A locked owner dropping valid after a response shall release ownership; the last-granted pointer shall then point to that owner.
REQ-018 Non-owner requests shall stall with req_ready 0 while state is not IDLE and no regrant applies.
REQ-019 mem_resp_valid in IDLE or ISSUE shall be ignored.
REQ-020 Best case, request acceptance to resp_valid shall be 3 cycles with mem_req_ready and mem_resp_valid each high on first opportunity.
REQ-021 resp_err shall be 0 except per REQ-030; resp_data shall hold its last value when no resp_valid.

Reset
REQ-022 With rst low at a clock edge: state IDLE, last-granted pointer "instruction" (data wins first), lock flag 0, all valid/ready outputs 0, resp_data 0, resp_err 0, mem_req_addr 0.
REQ-023 Reset mid-ISSUE or mid-WAIT shall abort silently; a later stray mem_resp_valid shall be ignored.

Configuration
REQ-030 With PTW_ARB_TIMEOUT_EN defined, an 8+-bit counter shall count WAIT cycles; reaching TIMEOUT_CYCLES shall pulse the owner's resp_valid with resp_err 1, resp_data 0, clear lock and return to IDLE; without it no counter exists, resp_err is tied 0 and WAIT is unbounded.

Structure
REQ-031 Package ptw_pkg shall hold the state enum, the owner enum (OWN_I, OWN_D) and the default widths.
REQ-032 A sub-module rr_arbiter2 (2-way round-robin, pointer update on grant) shall implement REQ-013; all else stays flat.

Verification
REQ-040 Only i_req_valid, addr 0x8000_1008, mem ready/resp immediate with data 0x0000_0000_2000_0C01 -> i_resp_valid 1 cycle, resp_data matches, 3 cycles after acceptance.
REQ-041 Both valid in the same cycle after reset, repeated 4 times -> grant order D, I, D, I.
REQ-042 d_req_lock 1 for three levels while i_req_valid constantly 1 -> three D transactions back-to-back, then I granted.
REQ-043 mem_req_ready low 5 cycles in ISSUE -> mem_req_valid/addr stable throughout; no extra responses.
REQ-044 rst low during WAIT, then mem_resp_valid -> no resp_valid; state IDLE.
REQ-045 With PTW_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, no mem_resp_valid -> resp_err 1 with owner resp_valid pulse after 10 WAIT cycles.
